// File: rtl/rr_stream_mux_pkg.sv
// Shared helpers for round-robin stream arbitration: select-index width and
// one-hot grant to binary index conversion.
package rr_stream_mux_pkg;

  // Widest grant vector the index helper accepts.
  localparam int MAX_N = 32;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int grant_to_idx(input logic [MAX_N-1:0] grant);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (grant[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_stream_mux_if.sv
// Handshake bundle for rr_stream_mux: N_IN producer lanes in, one consumer lane out.
interface rr_stream_mux_if #(
  parameter int N_IN  = 4,
  parameter int WIDTH = 8
);
  import rr_stream_mux_pkg::*;

  localparam int SEL_W = sel_w(N_IN);

  logic [N_IN-1:0]       in_valid;
  logic [N_IN-1:0]       in_ready;
  logic [N_IN*WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_sel;

  // Environment side: producers and consumer.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  // Mux side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/rr_stream_mux_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or
// after i_ptr, wrapping to the lowest request otherwise.
module rr_arbiter
  import rr_stream_mux_pkg::*;
#(
  parameter  int N_IN  = 4,
  localparam int SEL_W = sel_w(N_IN)
) (
  input  logic [N_IN-1:0]  i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [N_IN-1:0]  o_grant
);

  logic [N_IN-1:0] w_mask;
  logic [N_IN-1:0] w_high;
  logic [N_IN-1:0] w_pick;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_mask[i] = (i >= int'(i_ptr));
    end
  end

  // Requests at or above the pointer win; otherwise wrap to the full request set.
  assign w_high  = i_req & w_mask;
  assign w_pick  = (|w_high) ? w_high : i_req;
  assign o_grant = w_pick & (~w_pick + N_IN'(1));

endmodule

// File: rtl/rr_stream_mux.sv
// Round-robin N-to-1 stream mux with a registered output stage and source index.
module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  rr_stream_mux_if.slave bus
);

  localparam int SEL_W = sel_w(N_IN);

  logic [SEL_W-1:0] r_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_sel;

  logic             w_load;
  logic [N_IN-1:0]  w_grant;
  logic [WIDTH-1:0] w_sel_data;
  logic [SEL_W-1:0] w_idx;

  rr_arbiter #(.N_IN(N_IN)) u_arbiter (
    .i_req   (bus.in_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  assign w_load = !r_out_valid || bus.out_ready;
  assign w_idx  = SEL_W'(grant_to_idx(MAX_N'(w_grant)));

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_sel_data = w_sel_data | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
    end
  end

  // Gated by rst so sources never see ready while reset is held.
  assign bus.in_ready = (rst && w_load) ? w_grant : '0;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_load) begin
      if (|w_grant) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_sel   <= w_idx;
        r_ptr       <= (w_idx == SEL_W'(N_IN - 1)) ? '0 : w_idx + SEL_W'(1);
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench for rr_stream_mux (N_IN=4, WIDTH=8) against a
// cycle-level reference model of the round-robin rules.
module tb_rr_stream_mux;

  localparam int N = 4;
  localparam int W = 8;

  logic clk;
  logic rst;

  rr_stream_mux_if #(.N_IN(N), .WIDTH(W)) bus ();

  rr_stream_mux #(.N_IN(N), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Reference model state.
  bit       m_valid;
  bit [7:0] m_data;
  int       m_sel;
  int       m_ptr;
  bit [3:0] last_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_winner(input bit [3:0] v);
    for (int o = 0; o < N; o++) begin
      int k;
      k = (m_ptr + o) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic bit [3:0] m_ready();
    int w;
    if (!rst) return 4'b0000;
    if (m_valid && !bus.out_ready) return 4'b0000;
    w = m_winner(bus.in_valid);
    if (w < 0) return 4'b0000;
    return 4'(1 << w);
  endfunction

  task automatic m_reset();
    m_valid = 0;
    m_data  = 8'h00;
    m_sel   = 0;
    m_ptr   = 0;
  endtask

  task automatic m_update();
    int w;
    if (!rst) begin
      m_reset();
    end else if (!m_valid || bus.out_ready) begin
      w = m_winner(bus.in_valid);
      if (w >= 0) begin
        m_valid = 1;
        m_data  = bus.in_data[w*W +: W];
        m_sel   = w;
        m_ptr   = (w + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'(m_valid));
    if (m_valid) begin
      check({tag, "_data"}, 32'(bus.out_data), 32'(m_data));
      check({tag, "_sel"},  32'(bus.out_sel),  32'(m_sel));
    end
  endtask

  // Inputs are set by the caller just after a falling edge.
  task automatic cycle(input string tag);
    bit [3:0] exp_rdy;
    #1;
    exp_rdy = m_ready();
    check({tag, "_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
    last_acc = exp_rdy;
    @(posedge clk);
    m_update();
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic set_data_ramp(input bit [7:0] base);
    for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = base + 8'(i);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    last_acc      = '0;
    rst           = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    m_reset();

    // 1: reset held with all sources valid.
    @(negedge clk);
    for (int c = 0; c < 2; c++) cycle("t1_hold");
    check("t1_ready_held", 32'(bus.in_ready), 32'h0);
    rst = 1'b1;
    bus.in_valid = 4'b0000;
    cycle("t1_idle");
    check("t1_data_zero", 32'(bus.out_data), 32'h0);
    check("t1_sel_zero",  32'(bus.out_sel),  32'h0);

    // 2: single source.
    bus.in_valid = 4'b0001;
    bus.in_data[7:0] = 8'hA5;
    #1 check("t2_ready", 32'(bus.in_ready), 32'h1);
    cycle("t2");
    check("t2_data_A5", 32'(bus.out_data), 32'hA5);
    check("t2_sel_0",   32'(bus.out_sel),  32'h0);

    // 3: all valid, full throughput; pointer sits at 1 after test 2.
    bus.in_valid = 4'b1111;
    set_data_ramp(8'h10);
    for (int c = 0; c < 8; c++) begin
      cycle("t3");
      check("t3_nobubble", 32'(bus.out_valid), 32'h1);
      check("t3_sel_seq",  32'(bus.out_sel),   32'((1 + c) % N));
      check("t3_data_seq", 32'(bus.out_data),  32'(8'h10 + 8'((1 + c) % N)));
    end

    // 4: consumer stall then release.
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle("t4_stall");
      check("t4_sel_hold", 32'(bus.out_sel), 32'(8 % N));
    end
    bus.out_ready = 1'b1;
    #1 check("t4_release_ready", 32'(bus.in_ready), 32'h2);
    cycle("t4_release");

    // 5: grant to 2 then sources 0 and 3.
    bus.in_valid = 4'b0100;
    cycle("t5_g2");
    bus.in_valid = 4'b1001;
    cycle("t5_a");
    check("t5_sel_3", 32'(bus.out_sel), 32'h3);
    cycle("t5_b");
    check("t5_sel_0", 32'(bus.out_sel), 32'h0);

    // 6: asynchronous reset between edges.
    bus.in_valid = 4'b1111;
    cycle("t6_pre");
    #2 rst = 1'b0;
    m_reset();
    #1;
    check("t6_valid_async", 32'(bus.out_valid), 32'h0);
    check("t6_ready_async", 32'(bus.in_ready),  32'h0);
    @(negedge clk);
    cycle("t6_held");
    rst = 1'b1;
    cycle("t6_first");
    check("t6_first_sel", 32'(bus.out_sel), 32'h0);

    // Random traffic; sources hold valid/data until accepted.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(bus.in_valid[i] && !last_acc[i])) begin
          bus.in_valid[i] = ($urandom_range(0, 2) != 0);
          bus.in_data[i*W +: W] = 8'($urandom);
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
